gate_sensor_decoder: RTL and testbench
======================================

# gate_sensor_decoder

Upstream front end for the parking occupancy counter. Takes the two raw, asynchronous, bouncy beam sensors at the gate (outer `a`, inner `b`), synchronizes and debounces them, and decodes the order in which they break and clear. A completed crossing produces exactly one `enter` or `leave` pulse, which drives the occupancy counter's increment or decrement. Partial crossings, reversals, illegal sensor jumps and stalls produce no count pulse.

## Interface
Parameters:
- `DB_CYCLES`, default 1_000_000: consecutive cycles a synchronized input must differ from its debounced value before the debounced value follows it (≥1).
- `TIMEOUT_CYCLES`, default 500_000_000: maximum cycles spent in one tracking state before the crossing is aborted (≥2).

Ports:
- `clk`  in  1  system clock; one clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `a`  in  1  raw outer sensor, 1 = beam broken; asynchronous.
- `b`  in  1  raw inner sensor, 1 = beam broken; asynchronous.
- `enter`  out  1  one-cycle pulse when an entry completes.
- `leave`  out  1  one-cycle pulse when an exit completes.
- `busy`  out  1  high while the FSM is not IDLE.
- `fault`  out  1  one-cycle pulse when a crossing is aborted (illegal transition or timeout).

## Operation
- Sync: two flops per input (`a_s`, `b_s`). Reset value is 0.
- Debounce, per input: counter of width `$clog2(DB_CYCLES)`.
  - On each edge where sync != db:
    - If cnt == DB_CYCLES-1: db <= sync and cnt <= 0.
    - Else: cnt++.
  - On any edge where sync == db: cnt <= 0.
- Sensor code `s = {db_a, db_b}`.
- FSM states: IDLE, IN1, IN2, IN3, OUT1, OUT2, OUT3, WAIT_CLEAR.
- Transitions (any code not listed holds the state):
  - IDLE:
    - 10 goes to IN1.
    - 01 goes to OUT1.
    - 11 goes to WAIT_CLEAR and pulses `fault`.
  - IN1:
    - 11 goes to IN2.
    - 00 goes to IDLE (backed out, no pulse).
    - 01 goes to WAIT_CLEAR and pulses `fault`.
  - IN2:
    - 01 goes to IN3.
    - 10 goes to IN1.
    - 00 goes to WAIT_CLEAR and pulses `fault`.
  - IN3:
    - 00 goes to IDLE and pulses `enter`.
    - 11 goes to IN2.
    - 10 goes to WAIT_CLEAR and pulses `fault`.
  - OUT1/OUT2/OUT3: mirror of IN1/IN2/IN3 with a and b swapped. OUT3 going to IDLE on 00 pulses `leave`.
  - WAIT_CLEAR: 00 goes to IDLE. No pulse. Not subject to timeout.
- Timeout timer, width `$clog2(TIMEOUT_CYCLES)`:
  - Cleared on every state change and in IDLE/WAIT_CLEAR.
  - Increments each cycle otherwise.
  - At TIMEOUT_CYCLES-1 with no transition pending: go to WAIT_CLEAR and pulse `fault`.
  - A legal or illegal transition in the same cycle takes priority over the timeout.
- `enter`, `leave` and `fault` are mutually exclusive. None of them can assert on two consecutive cycles.
- `busy` is combinational from the state register: state != IDLE.

## Timing
- Reset values: all outputs 0; state IDLE; sync flops, db values, debounce counters and timer all 0.
- Raw input change to db update: exactly 2 + DB_CYCLES edges, provided the input is held stable.
- db update to FSM state and pulse: 1 edge. Pulses are registered and last exactly one cycle.
- Total latency from raw `b` falling to `enter` high: DB_CYCLES + 3 edges.
- Minimum spacing between `enter`/`leave` pulses: 4 debounced sensor changes.
- Reset mid-crossing: all pulses are suppressed and the FSM returns to IDLE on the reset edge.
  - If both sensors are still broken, db re-acquires 11 simultaneously. The FSM then reaches WAIT_CLEAR with `fault`, and no `enter`/`leave` follows for that vehicle.
- Both raw inputs changing in the same cycle debounce independently. A simultaneous db change is handled by the table above.

## Test plan
All scenarios use DB_CYCLES=4 and TIMEOUT_CYCLES=100.
1. Clean entry (a↑, b↑, a↓, b↓, each level held 20 cycles) -> single `enter` pulse 7 cycles after raw b↓; `leave` and `fault` stay 0; `busy` drops with the pulse.
2. Clean exit (b↑, a↑, b↓, a↓) -> single `leave` pulse 7 cycles after raw a↓; `enter` stays 0.
3. Bounce: `a` toggles every 2 cycles for 16 cycles, then rests at 0 -> db_a never changes; `busy`, `enter`, `leave` and `fault` stay 0.
4. Back-out and reversal:
   - a↑ then a↓ -> `busy` high then low, no pulse.
   - a↑, b↑, b↓, a↓ (IN2 back to IN1, then IDLE) -> no pulse.
5. Illegal and timeout:
   - a↑ then, same cycle, a↓ and b↑ (10 to 01) -> `fault` pulse and WAIT_CLEAR; `busy` stays high until both sensors clear.
   - `a` held high 300 cycles -> `fault` exactly 100 cycles after `busy` rises; no `enter`.
6. Reset mid-crossing in IN2 (a=b=1) -> outputs 0 the cycle after reset. After release: `fault` pulse and WAIT_CLEAR. Completing a↓, b↓ yields no `enter`.

Source files
------------

// File: rtl/gate_sensor_decoder.sv
// Gate beam-sensor front end: synchronizes and debounces the outer (a) and inner (b)
// beams, then decodes the break/clear order into enter, leave and fault pulses.
module gate_sensor_decoder #(
  parameter int DB_CYCLES      = 1_000_000,
  parameter int TIMEOUT_CYCLES = 500_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic a,
  input  logic b,
  output logic enter,
  output logic leave,
  output logic busy,
  output logic fault
);

  localparam int DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int TW  = $clog2(TIMEOUT_CYCLES);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);
  localparam logic [TW-1:0]  TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, IN1, IN2, IN3, OUT1, OUT2, OUT3, WAIT_CLEAR
  } state_t;

  typedef enum logic [1:0] {P_NONE, P_ENTER, P_LEAVE, P_FAULT} pulse_t;

  typedef struct packed {
    state_t nxt;
    pulse_t pulse;
  } step_t;

  // Bit 1 carries sensor a, bit 0 carries sensor b, so db reads as the code {a, b}.
  logic [1:0]     sync_meta;
  logic [1:0]     sync_s;
  logic [1:0]     db;
  logic [DBW-1:0] db_cnt [2];

  state_t        state;
  logic [TW-1:0] timer;
  step_t         tr;
  logic          tracking;
  logic          settle;

  // Sensor-order transition table; codes not listed keep the current state.
  function automatic step_t decode(input state_t st, input logic [1:0] code);
    step_t r;
    r.nxt   = st;
    r.pulse = P_NONE;
    case (st)
      IDLE: case (code)
        2'b10:   r.nxt = IN1;
        2'b01:   r.nxt = OUT1;
        2'b11:   begin r.nxt = WAIT_CLEAR; r.pulse = P_FAULT; end
        default: ;
      endcase
      IN1: case (code)
        2'b11:   r.nxt = IN2;
        2'b00:   r.nxt = IDLE;
        2'b01:   begin r.nxt = WAIT_CLEAR; r.pulse = P_FAULT; end
        default: ;
      endcase
      IN2: case (code)
        2'b01:   r.nxt = IN3;
        2'b10:   r.nxt = IN1;
        2'b00:   begin r.nxt = WAIT_CLEAR; r.pulse = P_FAULT; end
        default: ;
      endcase
      IN3: case (code)
        2'b00:   begin r.nxt = IDLE; r.pulse = P_ENTER; end
        2'b11:   r.nxt = IN2;
        2'b10:   begin r.nxt = WAIT_CLEAR; r.pulse = P_FAULT; end
        default: ;
      endcase
      OUT1: case (code)
        2'b11:   r.nxt = OUT2;
        2'b00:   r.nxt = IDLE;
        2'b10:   begin r.nxt = WAIT_CLEAR; r.pulse = P_FAULT; end
        default: ;
      endcase
      OUT2: case (code)
        2'b10:   r.nxt = OUT3;
        2'b01:   r.nxt = OUT1;
        2'b00:   begin r.nxt = WAIT_CLEAR; r.pulse = P_FAULT; end
        default: ;
      endcase
      OUT3: case (code)
        2'b00:   begin r.nxt = IDLE; r.pulse = P_LEAVE; end
        2'b11:   r.nxt = OUT2;
        2'b01:   begin r.nxt = WAIT_CLEAR; r.pulse = P_FAULT; end
        default: ;
      endcase
      WAIT_CLEAR: if (code == 2'b00) r.nxt = IDLE;
      default: ;
    endcase
    return r;
  endfunction

  // Stage: two-flop synchronizer followed by per-sensor debounce counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_meta <= '0;
      sync_s    <= '0;
      db        <= '0;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
    end else begin
      sync_meta <= {a, b};
      sync_s    <= sync_meta;
      for (int i = 0; i < 2; i++) begin
        if (sync_s[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db[i]     <= sync_s[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign tr       = decode(state, db);
  assign tracking = (state != IDLE) && (state != WAIT_CLEAR);
  // Holding IDLE for the cycle after a pulse keeps pulses from landing back to back.
  assign settle   = (state == IDLE) && (enter || leave || fault);

  // Stage: crossing FSM with stall timer and registered pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      timer <= '0;
      enter <= 1'b0;
      leave <= 1'b0;
      fault <= 1'b0;
    end else begin
      enter <= 1'b0;
      leave <= 1'b0;
      fault <= 1'b0;
      if ((tr.nxt != state) && !settle) begin
        state <= tr.nxt;
        timer <= '0;
        enter <= (tr.pulse == P_ENTER);
        leave <= (tr.pulse == P_LEAVE);
        fault <= (tr.pulse == P_FAULT);
      end else if (!tracking) begin
        timer <= '0;
      end else if (timer == TO_LAST) begin
        state <= WAIT_CLEAR;
        timer <= '0;
        fault <= 1'b1;
      end else begin
        timer <= timer + 1'b1;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_gate_sensor_decoder.sv
// Directed bench for gate_sensor_decoder: stimulus pushes expected pulses with their
// cycle stamp, a negedge monitor pops and compares each pulse the DUT emits.
module tb_gate_sensor_decoder;

  localparam int DB = 4;
  localparam int TO = 100;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic a = 1'b0;
  logic b = 1'b0;
  logic enter, leave, busy, fault;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [2:0] vec;
    int         at;
  } exp_t;

  exp_t sb[$];

  gate_sensor_decoder #(.DB_CYCLES(DB), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk),
    .reset(reset),
    .a(a),
    .b(b),
    .enter(enter),
    .leave(leave),
    .busy(busy),
    .fault(fault)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // vec is {enter, leave, fault}; dt is cycles from now until the pulse is visible.
  task automatic expect_pulse(input logic [2:0] v, input int dt);
    exp_t e;
    e.vec = v;
    e.at  = cyc + dt;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (enter || leave || fault) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", int'({enter, leave, fault}), 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("pulse_kind", int'({enter, leave, fault}), int'(e.vec));
        check("pulse_cycle", cyc, e.at);
      end
    end
  end

  initial begin
    wait_cyc(3);
    check("rst_busy", int'(busy), 0);
    check("rst_enter", int'(enter), 0);
    check("rst_leave", int'(leave), 0);
    check("rst_fault", int'(fault), 0);
    reset = 1'b0;
    wait_cyc(5);

    // Clean entry
    a = 1'b1; wait_cyc(20);
    b = 1'b1; wait_cyc(20);
    a = 1'b0; wait_cyc(20);
    b = 1'b0; expect_pulse(3'b100, 7);
    wait_cyc(6);
    check("entry_busy_before", int'(busy), 1);
    wait_cyc(1);
    check("entry_busy_drop", int'(busy), 0);
    wait_cyc(20);

    // Clean exit
    b = 1'b1; wait_cyc(20);
    a = 1'b1; wait_cyc(20);
    b = 1'b0; wait_cyc(20);
    a = 1'b0; expect_pulse(3'b010, 7);
    wait_cyc(6);
    check("exit_busy_before", int'(busy), 1);
    wait_cyc(1);
    check("exit_busy_drop", int'(busy), 0);
    wait_cyc(20);

    // Bounce on a never reaches the debounced value
    repeat (4) begin
      a = 1'b1; wait_cyc(2);
      a = 1'b0; wait_cyc(2);
    end
    wait_cyc(20);
    check("bounce_busy", int'(busy), 0);

    // Back-out
    a = 1'b1; wait_cyc(7);
    check("backout_busy_rise", int'(busy), 1);
    wait_cyc(13);
    a = 1'b0; wait_cyc(7);
    check("backout_busy_fall", int'(busy), 0);
    wait_cyc(13);

    // Reversal IN2 -> IN1 -> IDLE
    a = 1'b1; wait_cyc(20);
    b = 1'b1; wait_cyc(20);
    b = 1'b0; wait_cyc(20);
    check("reversal_in1_busy", int'(busy), 1);
    a = 1'b0; wait_cyc(20);
    check("reversal_idle_busy", int'(busy), 0);

    // Illegal jump 10 -> 01
    a = 1'b1; wait_cyc(20);
    a = 1'b0; b = 1'b1; expect_pulse(3'b001, 7);
    wait_cyc(20);
    check("illegal_wait_clear_busy", int'(busy), 1);
    b = 1'b0; wait_cyc(6);
    check("illegal_still_busy", int'(busy), 1);
    wait_cyc(1);
    check("illegal_cleared_busy", int'(busy), 0);
    wait_cyc(10);

    // Stall timeout: fault 100 cycles after busy rises (busy rises 7 after a)
    a = 1'b1; expect_pulse(3'b001, 7 + TO);
    wait_cyc(7);
    check("timeout_busy_rise", int'(busy), 1);
    wait_cyc(293);
    check("timeout_wait_clear_busy", int'(busy), 1);
    a = 1'b0; wait_cyc(7);
    check("timeout_cleared_busy", int'(busy), 0);
    wait_cyc(10);

    // Reset mid-crossing while in IN2
    a = 1'b1; wait_cyc(20);
    b = 1'b1; wait_cyc(20);
    check("midrst_in2_busy", int'(busy), 1);
    reset = 1'b1; wait_cyc(1);
    check("midrst_busy", int'(busy), 0);
    check("midrst_pulses", int'({enter, leave, fault}), 0);
    reset = 1'b0; expect_pulse(3'b001, 7);
    wait_cyc(20);
    check("midrst_wait_clear_busy", int'(busy), 1);
    a = 1'b0; wait_cyc(20);
    b = 1'b0; wait_cyc(20);
    check("midrst_final_busy", int'(busy), 0);

    wait_cyc(5);
    check("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
